// File: rtl/ysyx_25040109_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040109_lsu_pkg
//  Description : Shared encodings for the load/store bus initiator: access
//                sizes, bus response codes and the controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040109_lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Bus response code for a successful transfer
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } lsu_state_e;

    // True when the access cannot be served as a single naturally aligned beat.
    // Size 3 is not a legal encoding and is folded into the same trap.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25040109_lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040109_lsu_lane
//  Description : Byte-lane logic for a 32-bit bus: write strobe generation,
//                write-data replication, misalignment detection and read
//                data extraction with sign/zero extension. Purely
//                combinational so it can be shared with the fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040109_lsu_lane
    import ysyx_25040109_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Strobe and replicated store data so every lane the strobe may select holds the value
    always_comb begin
        strb      = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_B: begin
                strb      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                strb      = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_W: begin
                strb      = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                strb      = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    assign misalign = is_misaligned(size, addr_lo);

    // Bring the addressed lane down to bit 0, then truncate and extend
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        rdata_ext = shifted;
        case (size)
            SZ_B:    rdata_ext = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SZ_H:    rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25040109_lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040109_lsu_axi_master
//  Description : Load/store bus initiator. Converts one CPU load or store at a
//                time into a single-beat AR/R or AW/W/B transaction, with
//                misalignment trapping, response/ID checking and a one-cycle
//                completion pulse. All bus-facing outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040109_lsu_axi_master
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter logic [3:0] ID = 4'h1
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active low

    // CPU side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    // Read address / data
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    output logic [3:0]  mem_arid,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic [3:0]  mem_rid,
    input  logic        mem_rlast,

    // Write address / data / response
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [31:0] mem_awaddr,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_bvalid,
    output logic        mem_bready,
    input  logic [1:0]  mem_bresp
);

    lsu_state_e  state;
    lsu_state_e  next_state;

    // Latched request
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    // Write channel bookkeeping
    logic        aw_done;
    logic        w_done;
    logic        aw_done_nxt;
    logic        w_done_nxt;

    // Lane logic
    logic [1:0]  lane_addr;
    logic [1:0]  lane_size;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic        lane_misalign;
    logic [31:0] lane_rdata;

    // Completion values captured on entry to DONE
    logic        done_err;
    logic [31:0] done_rdata;

    logic        accept;

    assign req_ready   = (state == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign aw_done_nxt = aw_done || (mem_awvalid && mem_awready);
    assign w_done_nxt  = w_done  || (mem_wvalid  && mem_wready);
    assign mem_araddr  = addr_q;
    assign mem_awaddr  = addr_q;

    // In IDLE the lane sees the incoming request; afterwards the latched one
    assign lane_addr = (state == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign lane_size = (state == ST_IDLE) ? req_size      : size_q;

    ysyx_25040109_lsu_lane u_lane (
        .addr_lo     (lane_addr),
        .size        (lane_size),
        .is_unsigned (unsigned_q),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .strb        (lane_strb),
        .wdata_rep   (lane_wdata),
        .misalign    (lane_misalign),
        .rdata_ext   (lane_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the completion status that goes with entering DONE
    always_comb begin
        next_state = state;
        done_err   = 1'b0;
        done_rdata = 32'h0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (lane_misalign) begin
                        next_state = ST_DONE;
                        done_err   = 1'b1;
                    end else if (req_wen) begin
                        next_state = ST_WR_REQ;
                    end else begin
                        next_state = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (mem_arvalid && mem_arready) begin
                    next_state = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (mem_rvalid) begin
                    next_state = ST_DONE;
                    done_err   = (mem_rresp != RESP_OKAY) || (mem_rid != ID) || !mem_rlast;
                    done_rdata = done_err ? 32'h0 : lane_rdata;
                end
            end
            ST_WR_REQ: begin
                if (aw_done_nxt && w_done_nxt) begin
                    next_state = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (mem_bvalid) begin
                    next_state = ST_DONE;
                    done_err   = (mem_bresp != RESP_OKAY);
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered bus and response outputs, derived from where the FSM is heading
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_wvalid  <= 1'b0;
            mem_bready  <= 1'b0;
            mem_arid    <= 4'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'h0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            addr_q      <= 32'h0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'h0;
        end else begin
            mem_arvalid <= (next_state == ST_RD_ADDR);
            mem_rready  <= (next_state == ST_RD_DATA);
            mem_awvalid <= (next_state == ST_WR_REQ) && !aw_done_nxt;
            mem_wvalid  <= (next_state == ST_WR_REQ) && !w_done_nxt;
            aw_done     <= (next_state == ST_WR_REQ) && aw_done_nxt;
            w_done      <= (next_state == ST_WR_REQ) && w_done_nxt;
            mem_bready  <= (next_state == ST_WR_RESP);
            mem_arid    <= ID;
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                mem_wdata  <= lane_wdata;
                mem_wstrb  <= lane_strb;
            end
            resp_valid  <= (next_state == ST_DONE);
            resp_err    <= done_err;
            resp_rdata  <= done_rdata;
        end
    end

endmodule
`default_nettype wire
